// File: rtl/raw_data_rx_fsm.sv
// Receive side of the raw_data_valid / raw_data_accepted handshake: captures one word,
// pushes {last, index, data} into the processing FIFO, and frames words into blocks.
// Optional index-sequence checking is enabled with `define RAW_RX_SEQ_CHECK_EN.
//
// state    | meaning
// S_INIT   | first cycle out of reset, nothing offered to the sender
// S_ACCEPT | waiting for a word, raw_data_accepted=1
// S_PUSH   | holding the captured word until the FIFO has room
// S_DONE   | one-cycle block_done pulse after the last word of a block
module raw_data_rx_fsm #(
  parameter int DATA_W    = 32,
  parameter int IDX_W     = 8,
  parameter int BLOCK_LEN = 16,
  parameter int CNT_W     = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      raw_data_valid,
  input  logic [DATA_W-1:0]         raw_data_in,
  input  logic [IDX_W-1:0]          raw_index_in,
  output logic                      raw_data_accepted,
  input  logic                      proc_fifo_full,
  output logic                      proc_fifo_push,
  output logic [IDX_W+DATA_W:0]     proc_fifo_data,
  output logic                      block_done,
  output logic [CNT_W-1:0]          word_count,
  output logic                      seq_error
);

  localparam int                 OFF_W    = $clog2(BLOCK_LEN);
  localparam int                 FIFO_W   = 1 + IDX_W + DATA_W;
  localparam logic [OFF_W-1:0]   LAST_OFF = OFF_W'(BLOCK_LEN - 1);

  typedef enum logic [3:0] {
    S_INIT   = 4'b0001,
    S_ACCEPT = 4'b0010,
    S_PUSH   = 4'b0100,
    S_DONE   = 4'b1000
  } state_t;

  state_t            state, state_nxt;
  logic [OFF_W-1:0]  word_off;
  logic              capture;
  logic              held_last;

  assign held_last = proc_fifo_data[FIFO_W-1];

  always_ff @(posedge clk) begin
    if (reset) state <= S_INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt         = S_INIT;
    raw_data_accepted = 1'b0;
    proc_fifo_push    = 1'b0;
    block_done        = 1'b0;
    capture           = 1'b0;
    case (state)
      S_INIT: state_nxt = S_ACCEPT;
      S_ACCEPT: begin
        raw_data_accepted = 1'b1;
        if (raw_data_valid) begin
          capture   = 1'b1;
          state_nxt = S_PUSH;
        end else begin
          state_nxt = S_ACCEPT;
        end
      end
      S_PUSH: begin
        if (proc_fifo_full) begin
          state_nxt = S_PUSH;
        end else begin
          proc_fifo_push = 1'b1;
          state_nxt      = held_last ? S_DONE : S_ACCEPT;
        end
      end
      S_DONE: begin
        block_done = 1'b1;
        state_nxt  = S_ACCEPT;
      end
      default: state_nxt = S_INIT;
    endcase
  end

  // Offset advances on the push, not the capture, so a word discarded by reset never counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      proc_fifo_data <= '0;
      word_off       <= '0;
      word_count     <= '0;
    end else begin
      if (capture)
        proc_fifo_data <= {(word_off == LAST_OFF), raw_index_in, raw_data_in};
      if (proc_fifo_push) begin
        if (word_count != {CNT_W{1'b1}})
          word_count <= word_count + CNT_W'(1);
        if (held_last) word_off <= '0;
        else           word_off <= word_off + OFF_W'(1);
      end
    end
  end

`ifdef RAW_RX_SEQ_CHECK_EN
  logic [IDX_W-1:0] exp_idx;
  logic             seq_err_q;

  // Expected index always follows the received one, so a single gap flags once and resyncs.
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_idx   <= '0;
      seq_err_q <= 1'b0;
    end else if (capture) begin
      if (raw_index_in != exp_idx) seq_err_q <= 1'b1;
      exp_idx <= raw_index_in + IDX_W'(1);
    end
  end

  assign seq_error = seq_err_q;
`else
  assign seq_error = 1'b0;
`endif

endmodule

// File: tb/tb_raw_data_rx_fsm.sv
// Randomized bench for raw_data_rx_fsm against a cycle-level behavioural model of the
// handshake, block framing, saturating count and index-sequence rule.
module tb_raw_data_rx_fsm;
  localparam int DATA_W    = 32;
  localparam int IDX_W     = 8;
  localparam int BLOCK_LEN = 4;
  localparam int CNT_W     = 4;
  localparam int FIFO_W    = 1 + IDX_W + DATA_W;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              raw_data_valid = 1'b0;
  logic [DATA_W-1:0] raw_data_in = '0;
  logic [IDX_W-1:0]  raw_index_in = '0;
  logic              raw_data_accepted;
  logic              proc_fifo_full = 1'b0;
  logic              proc_fifo_push;
  logic [FIFO_W-1:0] proc_fifo_data;
  logic              block_done;
  logic [CNT_W-1:0]  word_count;
  logic              seq_error;

  raw_data_rx_fsm #(.DATA_W(DATA_W), .IDX_W(IDX_W), .BLOCK_LEN(BLOCK_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .raw_data_valid(raw_data_valid), .raw_data_in(raw_data_in),
    .raw_index_in(raw_index_in), .raw_data_accepted(raw_data_accepted),
    .proc_fifo_full(proc_fifo_full), .proc_fifo_push(proc_fifo_push),
    .proc_fifo_data(proc_fifo_data), .block_done(block_done), .word_count(word_count),
    .seq_error(seq_error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model: receiver is either starting up, idle, holding one word, or signalling a block end
  bit                model_ok = 0;
  bit                m_init, m_hold, m_done, m_err;
  int                m_pos, m_cnt;
  logic [FIFO_W-1:0] m_word;
  logic [IDX_W-1:0]  m_exp;
  bit                xfer;

  int                v_pct = 0, f_pct = 0, j_pct = 0;
  logic [IDX_W-1:0]  nxt_idx = '0;
  int                xfers = 0;
  int                pushes = 0;
  int                force_at = -1;
  logic [IDX_W-1:0]  force_val = '0;
  bit                exp_seq;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle();
    bit e_acc, e_push;
    @(negedge clk);
    e_acc  = !m_init && !m_hold && !m_done;
    e_push = m_hold && !proc_fifo_full;
    if (model_ok) begin
`ifdef RAW_RX_SEQ_CHECK_EN
      exp_seq = m_err;
`else
      exp_seq = 1'b0;
`endif
      chk("accepted", 64'(raw_data_accepted), 64'(e_acc));
      chk("push", 64'(proc_fifo_push), 64'(e_push));
      chk("block_done", 64'(block_done), 64'(m_done));
      chk("word_count", 64'(word_count), 64'((m_cnt > CNT_MAX) ? CNT_MAX : m_cnt));
      chk("seq_error", 64'(seq_error), 64'(exp_seq));
      if (m_hold) chk("fifo_data", 64'(proc_fifo_data), 64'(m_word));
    end
    xfer = 0;
    if (reset) begin
      model_ok = 1; m_init = 1; m_hold = 0; m_done = 0; m_err = 0;
      m_pos = 0; m_cnt = 0; m_exp = '0; m_word = '0;
    end else if (model_ok) begin
      m_init = 0;
      m_done = 0;
      if (e_push) begin
        pushes++;
        m_hold = 0;
        m_cnt++;
        if (m_word[FIFO_W-1]) begin m_done = 1; m_pos = 0; end
        else m_pos++;
      end
      if (e_acc && raw_data_valid) begin
        xfer = 1;
        xfers++;
        m_hold = 1;
        m_word = {(m_pos == BLOCK_LEN - 1), raw_index_in, raw_data_in};
        if (raw_index_in != m_exp) m_err = 1;
        m_exp = raw_index_in + IDX_W'(1);
      end
    end
    @(posedge clk);
    #1;
    if (!(raw_data_valid && !xfer)) begin
      raw_data_valid = ($urandom_range(99) < v_pct);
      if (raw_data_valid) begin
        raw_data_in = $urandom;
        if (xfers == force_at) nxt_idx = force_val;
        raw_index_in = ($urandom_range(99) < j_pct) ? IDX_W'($urandom) : nxt_idx;
        nxt_idx = raw_index_in + IDX_W'(1);
      end
    end
    proc_fifo_full = ($urandom_range(99) < f_pct);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    raw_data_valid = 1'b0;
    nxt_idx = '0;
    xfers = 0;
    pushes = 0;
    repeat (n) cycle();
    reset = 1'b0;
  endtask

  initial begin
    // reset then idle
    do_reset(2);
    repeat (4) cycle();
    chk("idle_pushes", 64'(pushes), 64'(0));

    // streaming, no backpressure
    v_pct = 100; f_pct = 0; j_pct = 0;
    repeat (30) cycle();
    chk("stream_min_words", 64'(pushes >= 8), 64'(1));

    // backpressure held while a word is pending
    f_pct = 100;
    repeat (7) cycle();
    f_pct = 0;
    repeat (4) cycle();

    // reset while holding a word
    f_pct = 100;
    repeat (3) cycle();
    do_reset(1);
    f_pct = 0;
    repeat (10) cycle();

    // saturation: well over 15 words
    repeat (60) cycle();
    chk("sat_count", 64'(word_count), 64'(CNT_MAX));
    chk("sat_pushes_gt_20", 64'(pushes >= 20), 64'(1));

    // index gap 0,1,2,5,6
    v_pct = 0;
    do_reset(2);
    force_at = 3; force_val = IDX_W'(5);
    v_pct = 100;
    repeat (14) cycle();
    force_at = -1;
`ifdef RAW_RX_SEQ_CHECK_EN
    chk("seq_gap", 64'(seq_error), 64'(1));
`else
    chk("seq_gap", 64'(seq_error), 64'(0));
`endif

    // random traffic with occasional resets
    v_pct = 0;
    do_reset(1);
    v_pct = 60; f_pct = 40; j_pct = 3;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(499) == 0) do_reset(1 + $urandom_range(1));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
